// File: rtl/renderer_blend_writer.sv
// Read-modify-write sequencer that blends one pixel into the framebuffer.
// Ports: i_pixel_* request in, o/i_mem_read_* and o/i_mem_write_* memory,
//        o_mix_* / i_mix_final_color to the external mixer, o_busy status.
module renderer_blend_writer #(
   parameter int ADDR_WIDTH    = 18,
   parameter int MIXER_LATENCY = 4
) (
   input  logic                  i_master_clk,
   input  logic                  i_reset_n,
   input  logic                  i_pixel_valid,
   output logic                  o_pixel_ready,
   input  logic [ADDR_WIDTH-1:0] i_pixel_address,
   input  logic [11:0]           i_pixel_color,
   input  logic [3:0]            i_pixel_alpha,
   output logic                  o_mem_read_request,
   output logic [ADDR_WIDTH-1:0] o_mem_read_address,
   input  logic                  i_mem_read_ack,
   input  logic [11:0]           i_mem_read_data,
   output logic                  o_mem_write_request,
   output logic [ADDR_WIDTH-1:0] o_mem_write_address,
   output logic [11:0]           o_mem_write_data,
   input  logic                  i_mem_write_ack,
   output logic [11:0]           o_mix_original_color,
   output logic [11:0]           o_mix_new_color,
   output logic [3:0]            o_mix_alpha,
   input  logic [11:0]           i_mix_final_color,
   output logic                  o_busy
);

   localparam int CW = $clog2(MIXER_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      MIX,
      WRITE
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [11:0]           color_q;
   logic [11:0]           orig_q;
   logic [11:0]           wdata_q;
   logic [3:0]            alpha_q;
   logic [CW-1:0]         cnt_q;
   logic                  ready_q;
   logic                  rreq_q;
   logic                  wreq_q;
   logic                  busy_q;

   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         color_q <= '0;
         orig_q  <= '0;
         wdata_q <= '0;
         alpha_q <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         rreq_q  <= 1'b0;
         wreq_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // ready comes up on the first edge after reset release
               ready_q <= 1'b1;
               if (i_pixel_valid && ready_q) begin
                  addr_q  <= i_pixel_address;
                  color_q <= i_pixel_color;
                  alpha_q <= i_pixel_alpha;
                  if (i_pixel_alpha == 4'hF) begin
                     // opaque: no need to read or mix
                     wdata_q <= i_pixel_color;
                     wreq_q  <= 1'b1;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= WRITE;
                  end else if (i_pixel_alpha != 4'h0) begin
                     rreq_q  <= 1'b1;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               if (i_mem_read_ack) begin
                  orig_q  <= i_mem_read_data;
                  cnt_q   <= '0;
                  rreq_q  <= 1'b0;
                  state_q <= MIX;
               end
            end
            MIX: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(MIXER_LATENCY)) begin
                  wdata_q <= i_mix_final_color;
                  wreq_q  <= 1'b1;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (i_mem_write_ack) begin
                  wreq_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_pixel_ready        = ready_q;
   assign o_mem_read_request   = rreq_q;
   assign o_mem_read_address   = addr_q;
   assign o_mem_write_request  = wreq_q;
   assign o_mem_write_address  = addr_q;
   assign o_mem_write_data     = wdata_q;
   assign o_mix_original_color = orig_q;
   assign o_mix_new_color      = color_q;
   assign o_mix_alpha          = alpha_q;
   assign o_busy               = busy_q;

endmodule

// File: tb/tb_renderer_blend_writer.sv
// Bench for renderer_blend_writer: memory responder, 4-stage mixer model,
// write scoreboard and directed plus randomized pixel sequences.
module tb_renderer_blend_writer;

   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pv = 1'b0;
   logic          pr;
   logic [AW-1:0] pa = '0;
   logic [11:0]   pc = '0;
   logic [3:0]    pal = '0;
   logic          rreq;
   logic [AW-1:0] raddr;
   logic          rack = 1'b0;
   logic [11:0]   rdata = '0;
   logic          wreq;
   logic [AW-1:0] waddr;
   logic [11:0]   wdata;
   logic          wack = 1'b0;
   logic [11:0]   mo;
   logic [11:0]   mn;
   logic [3:0]    ma;
   logic [11:0]   mf;
   logic          busy;

   always #5 clk = ~clk;

   renderer_blend_writer #(.ADDR_WIDTH(AW), .MIXER_LATENCY(4)) dut (
      .i_master_clk(clk),
      .i_reset_n(rst_n),
      .i_pixel_valid(pv),
      .o_pixel_ready(pr),
      .i_pixel_address(pa),
      .i_pixel_color(pc),
      .i_pixel_alpha(pal),
      .o_mem_read_request(rreq),
      .o_mem_read_address(raddr),
      .i_mem_read_ack(rack),
      .i_mem_read_data(rdata),
      .o_mem_write_request(wreq),
      .o_mem_write_address(waddr),
      .o_mem_write_data(wdata),
      .i_mem_write_ack(wack),
      .o_mix_original_color(mo),
      .o_mix_new_color(mn),
      .o_mix_alpha(ma),
      .i_mix_final_color(mf),
      .o_busy(busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int nreads = 0;
   int nwrites = 0;
   int rd_delay = 0;
   int wr_delay = 0;
   bit stray = 1'b0;

   logic [11:0] mem [int];

   typedef struct packed {
      logic [AW-1:0] a;
      logic [11:0]   d;
   } wr_t;

   wr_t expq[$];
   wr_t gotq[$];

   function automatic logic [11:0] blend(logic [11:0] n, logic [11:0] o,
                                         logic [3:0] a);
      logic [11:0] r;
      int ai;
      ai = int'(a);
      r = '0;
      for (int c = 0; c < 3; c++) begin
         int nv;
         int ov;
         nv = int'(n[c*4 +: 4]);
         ov = int'(o[c*4 +: 4]);
         r[c*4 +: 4] = 4'((nv * ai + ov * (15 - ai)) / 15);
      end
      return r;
   endfunction

   function automatic logic [11:0] memrd(int a);
      if (mem.exists(a)) return mem[a];
      return 12'(a * 37 + 5);
   endfunction

   // external 4-stage mixer
   logic [11:0] s1 = '0;
   logic [11:0] s2 = '0;
   logic [11:0] s3 = '0;
   logic [11:0] s4 = '0;
   assign mf = s4;
   always @(posedge clk) begin
      s1 <= blend(mn, mo, ma);
      s2 <= s1;
      s3 <= s2;
      s4 <= s3;
      cyc <= cyc + 1;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // memory responder: acks after a programmable wait, checks hold
   initial begin
      int rcnt;
      int wcnt;
      logic [AW-1:0] rh;
      logic [AW-1:0] wh;
      logic [11:0]   wdh;
      rcnt = 0;
      wcnt = 0;
      rh = '0;
      wh = '0;
      wdh = '0;
      forever begin
         @(negedge clk);
         rack = 1'b0;
         wack = 1'b0;
         if (!rst_n) begin
            rcnt = 0;
            wcnt = 0;
         end else begin
            if (rreq) begin
               if (rcnt == 0) rh = raddr;
               else chk("rd_addr_hold", raddr, rh);
               if (rcnt >= rd_delay) begin
                  rack = 1'b1;
                  rdata = memrd(int'(raddr));
                  nreads++;
                  rcnt = 0;
               end else rcnt++;
            end else begin
               rcnt = 0;
               if (stray && $urandom_range(0, 3) == 0) begin
                  rack = 1'b1;
                  rdata = 12'($urandom);
               end
            end
            if (wreq) begin
               if (wcnt == 0) begin
                  wh = waddr;
                  wdh = wdata;
               end else begin
                  chk("wr_addr_hold", waddr, wh);
                  chk("wr_data_hold", wdata, wdh);
               end
               if (wcnt >= wr_delay) begin
                  wack = 1'b1;
                  gotq.push_back({waddr, wdata});
                  mem[int'(waddr)] = wdata;
                  nwrites++;
                  wcnt = 0;
               end else wcnt++;
            end else begin
               wcnt = 0;
               if (stray && $urandom_range(0, 3) == 0) wack = 1'b1;
            end
         end
      end
   end

   task automatic issue(logic [AW-1:0] a, logic [11:0] c, logic [3:0] al,
                        bit hold, output int acc);
      int n;
      n = 0;
      pv = 1'b1;
      pa = a;
      pc = c;
      pal = al;
      while (!pr && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", 32'(n < 100), 1);
      if (al == 4'hF) expq.push_back({a, c});
      else if (al != 4'h0) expq.push_back({a, blend(c, memrd(int'(a)), al)});
      @(posedge clk);
      #1;
      acc = cyc;
      if (!hold) pv = 1'b0;
   endtask

   task automatic wait_ready(output int n, output int rf, output int wf);
      n = 0;
      rf = -1;
      wf = -1;
      do begin
         @(negedge clk);
         n++;
         if (rreq && rf < 0) rf = n;
         if (wreq && wf < 0) wf = n;
      end while (!pr && n < 200);
      chk("ready_in_time", 32'(n < 200), 1);
   endtask

   task automatic drain();
      chk("wr_count", gotq.size(), expq.size());
      while (gotq.size() > 0 && expq.size() > 0) begin
         wr_t g;
         wr_t e;
         g = gotq.pop_front();
         e = expq.pop_front();
         chk("wr_addr", g.a, e.a);
         chk("wr_data", g.d, e.d);
      end
      gotq.delete();
      expq.delete();
   endtask

   initial begin
      int acc0;
      int acc1;
      int n;
      int rf;
      int wf;
      int r0;
      int w0;
      int al;
      int accs[3];

      repeat (3) @(negedge clk);
      chk("rst_ready", pr, 0);
      chk("rst_rreq", rreq, 0);
      chk("rst_wreq", wreq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_mix_o", mo, 0);
      chk("rst_mix_n", mn, 0);
      chk("rst_mix_a", ma, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", pr, 1);
      chk("post_rst_busy", busy, 0);

      // transparent, then opaque accepted on the very next cycle
      r0 = nreads;
      w0 = nwrites;
      issue(18'h00123, 12'hABC, 4'h0, 1'b0, acc0);
      wait_ready(n, rf, wf);
      chk("transp_ready", n, 1);
      chk("transp_rreq", rf, -1);
      chk("transp_wreq", wf, -1);
      issue(18'h00123, 12'hABC, 4'hF, 1'b0, acc1);
      chk("transp_next_acc", acc1 - acc0, 1);
      wait_ready(n, rf, wf);
      chk("opq_ready", n, 2);
      chk("opq_wreq_cyc", wf, 1);
      chk("opq_no_read", rf, -1);
      chk("opq_reads", nreads - r0, 0);
      chk("opq_writes", nwrites - w0, 1);
      chk("opq_mem", memrd(32'h123), 12'hABC);
      drain();

      // directed blend at the top address
      mem[32'h3FFFF] = 12'h0F0;
      issue(18'h3FFFF, 12'hF00, 4'h8, 1'b0, acc0);
      wait_ready(n, rf, wf);
      chk("blend_ready", n, 8);
      chk("blend_rreq_cyc", rf, 1);
      chk("blend_wreq_cyc", wf, 7);
      chk("blend_mem", memrd(32'h3FFFF), 12'h870);
      drain();

      // delayed acks with stray acks on idle ports
      rd_delay = 5;
      wr_delay = 3;
      stray = 1'b1;
      r0 = nreads;
      w0 = nwrites;
      issue(18'h1C0DE, 12'h5A3, 4'h6, 1'b0, acc0);
      wait_ready(n, rf, wf);
      chk("dly_ready", n, 16);
      chk("dly_rreq_cyc", rf, 1);
      chk("dly_wreq_cyc", wf, 12);
      chk("dly_reads", nreads - r0, 1);
      chk("dly_writes", nwrites - w0, 1);
      drain();
      rd_delay = 0;
      wr_delay = 0;
      stray = 1'b0;

      // valid held for three back-to-back pixels
      for (int i = 0; i < 3; i++) begin
         issue(18'(32'h200 + i), 12'(32'h3C5 + i * 32'h111), 4'h4, 1'b1,
               accs[i]);
         if (i > 0) chk("b2b_spacing", accs[i] - accs[i-1], 8);
         if (i == 2) pv = 1'b0;
         wait_ready(n, rf, wf);
         chk("b2b_ready", n, 8);
      end
      drain();

      // randomized pixels with random wait states
      stray = 1'b1;
      for (int i = 0; i < 25; i++) begin
         rd_delay = $urandom_range(0, 3);
         wr_delay = $urandom_range(0, 3);
         al = (i % 5 == 0) ? 15 : (i % 7 == 0) ? 0 : $urandom_range(0, 15);
         issue(18'($urandom), 12'($urandom), 4'(al), 1'b0, acc0);
         wait_ready(n, rf, wf);
         if (al == 0) chk("rnd_ready", n, 1);
         else if (al == 15) chk("rnd_ready", n, 2 + wr_delay);
         else chk("rnd_ready", n, 8 + rd_delay + wr_delay);
         drain();
      end
      stray = 1'b0;
      rd_delay = 0;
      wr_delay = 0;

      // reset during MIX after the read was acked
      r0 = nreads;
      w0 = nwrites;
      issue(18'h0A5A5, 12'h123, 4'h5, 1'b0, acc0);
      repeat (4) @(negedge clk);
      chk("mix_busy", busy, 1);
      chk("mix_ready", pr, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_rreq", rreq, 0);
      chk("abort_wreq", wreq, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", pr, 0);
      void'(expq.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_reads", nreads - r0, 1);
      chk("abort_writes", nwrites - w0, 0);
      chk("abort_ready_after", pr, 1);
      chk("abort_busy_after", busy, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
